// File: rtl/postbox_pkg.sv
// Shared definitions for the POST port INPUT engine: slot state encoding,
// the preamble ACK value and the default break length.
package postbox_pkg;

    // Slot that the next host REQ pulse will sample.
    typedef enum logic [2:0] {
        ST_PRE1,
        ST_PRE2,
        ST_X,
        ST_Y,
        ST_DATA
    } slot_e;

    // ACK value presented in both preamble slots.
    localparam logic ACK_PREAMBLE = 1'b0;

    // 25 us of REQ low at a 16 MHz refclk.
    localparam int DEFAULT_BREAK_CYCLES = 400;

endpackage

// File: rtl/postbox_txfifo.sv
// Transmit word store for the POST port INPUT engine.
// Build option: define POSTBOX_TXFIFO_EN for a DEPTH-entry FIFO; otherwise a
// single holding register is used and DEPTH only sets the default level width.
// A write while full is dropped, even when a read happens in the same cycle.
module postbox_txfifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [LVL_W-1:0]  o_level
);

`ifdef POSTBOX_TXFIFO_EN
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [LVL_W-1:0]  r_level;
    logic              r_full;
    logic [LVL_W-1:0]  w_level_nxt;
    logic              w_wr_acc;
    logic              w_rd_acc;

    assign w_wr_acc = i_wr & ~r_full;
    assign w_rd_acc = i_rd & (r_level != '0);

    // Next occupancy from the accepted write/read pair.
    // NOTE: combinational blocks assign a default first so no path leaves a value held (no latch).
    always_comb begin
        w_level_nxt = r_level;
        if (w_wr_acc && !w_rd_acc) begin
            w_level_nxt = r_level + LVL_W'(1);
        end else if (!w_wr_acc && w_rd_acc) begin
            w_level_nxt = r_level - LVL_W'(1);
        end
    end

    // Word storage.
    // NOTE: the array has no reset; the level/pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; full is registered.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == LVL_W'(DEPTH));
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_full    = r_full;
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
`else
    logic [DATA_W-1:0] r_hold;
    logic              r_valid;

    // Single holding register: a write lands only when it is free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold  <= '0;
            r_valid <= 1'b0;
        end else begin
            if (i_wr && !r_valid) begin
                r_hold  <= i_wr_data;
                r_valid <= 1'b1;
            end else if (i_rd) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_rd_data = r_hold;
    assign o_full    = r_valid;
    assign o_empty   = ~r_valid;
    assign o_level   = LVL_W'(r_valid);
`endif

endmodule

// File: rtl/postbox_input_engine.sv
// Pod-side POST port INPUT engine: synchronises host REQ, detects breaks and
// drives ACK with preamble, x (out_ready), y (word available) and MSB-first data.
// Build option: POSTBOX_TXFIFO_EN selects a FIFO_DEPTH-entry transmit FIFO
// instead of a single holding register.
module postbox_input_engine
    import postbox_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int BREAK_CYCLES = DEFAULT_BREAK_CYCLES,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                          refclk,
    input  logic                          rst_n,
    input  logic                          testreq,
    output logic                          testack,
    input  logic                          out_ready,
    input  logic [DATA_W-1:0]             tx_data,
    input  logic                          tx_wr,
    output logic                          tx_full,
    output logic [$clog2(FIFO_DEPTH):0]   tx_level,
    output logic                          word_sent,
    output logic                          word_abort,
    output logic                          break_det
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int BRK_W = $clog2(BREAK_CYCLES);
    localparam logic [BRK_W-1:0] BRK_MAX  = BRK_W'(BREAK_CYCLES - 1);
    localparam logic [BRK_W-1:0] BRK_FIRE = BRK_W'(BREAK_CYCLES - 2);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_req_d;
    logic [BRK_W-1:0]       r_brk_cnt;
    slot_e                  r_state;
    logic                   r_ack;
    logic [DATA_W-1:0]      r_shift;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic                   r_word_sent;
    logic                   r_word_abort;
    logic                   r_break_det;

    logic                   w_req;
    logic                   w_req_rise;
    logic                   w_req_edge;
    logic                   w_break;
    logic                   w_last_bit;
    logic                   w_y_load;
    logic                   w_pop;
    logic [DATA_W-1:0]      w_fifo_head;
    logic                   w_fifo_empty;

    assign w_req      = r_sync[SYNC_STAGES-1];
    assign w_req_rise = w_req & ~r_req_d;
    assign w_req_edge = w_req ^ r_req_d;

    // Break fires on the cycle the low-time counter reaches its saturation value.
    assign w_break    = ~w_req & ~w_req_edge & (r_brk_cnt == BRK_FIRE);

    assign w_last_bit = (r_bit_cnt == CNT_W'(DATA_W - 1));

    // A y slot is (re)loaded after X, after a y=0 pulse, and after the last data bit.
    // r_ack holds y while in ST_Y. A break can never coincide with a rise.
    assign w_y_load = w_req_rise &
                      ((r_state == ST_X) ||
                       ((r_state == ST_Y) && !r_ack) ||
                       ((r_state == ST_DATA) && w_last_bit));
    assign w_pop    = w_y_load & ~w_fifo_empty;

    postbox_txfifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH),
        .LVL_W  (LVL_W)
    ) u_txfifo (
        .clk       (refclk),
        .rst_n     (rst_n),
        .i_wr      (tx_wr),
        .i_wr_data (tx_data),
        .i_rd      (w_pop),
        .o_rd_data (w_fifo_head),
        .o_full    (tx_full),
        .o_empty   (w_fifo_empty),
        .o_level   (tx_level)
    );

    // REQ synchroniser plus one delayed copy for edge detection.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= '0;
            r_req_d <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], testreq};
            r_req_d <= w_req;
        end
    end

    // Low-time counter: cleared by any REQ edge, saturates so a break fires once.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_brk_cnt <= '0;
        end else if (w_req_edge) begin
            r_brk_cnt <= '0;
        end else if (!w_req && (r_brk_cnt != BRK_MAX)) begin
            r_brk_cnt <= r_brk_cnt + BRK_W'(1);
        end
    end

    // Slot FSM: r_ack always holds the bit the next REQ rise will sample.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_PRE1;
            r_ack        <= ACK_PREAMBLE;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_word_sent  <= 1'b0;
            r_word_abort <= 1'b0;
            r_break_det  <= 1'b0;
        end else begin
            r_word_sent  <= 1'b0;
            r_word_abort <= 1'b0;
            r_break_det  <= 1'b0;
            if (w_break) begin
                // Any word already popped is dropped; the FIFO itself is not touched.
                r_state      <= ST_PRE1;
                r_ack        <= ACK_PREAMBLE;
                r_shift      <= '0;
                r_bit_cnt    <= '0;
                r_break_det  <= 1'b1;
                r_word_abort <= (r_state == ST_DATA);
            end else if (w_y_load) begin
                r_state     <= ST_Y;
                r_ack       <= ~w_fifo_empty;
                r_word_sent <= (r_state == ST_DATA);
                if (!w_fifo_empty) begin
                    r_shift <= w_fifo_head;
                end
            end else if (w_req_rise) begin
                case (r_state)
                    ST_PRE1: begin
                        r_state <= ST_PRE2;
                        r_ack   <= ACK_PREAMBLE;
                    end
                    ST_PRE2: begin
                        r_state <= ST_X;
                        r_ack   <= out_ready;
                    end
                    ST_Y: begin
                        // y=1 was just sampled: present the MSB of the loaded word.
                        r_state   <= ST_DATA;
                        r_ack     <= r_shift[DATA_W-1];
                        r_shift   <= {r_shift[DATA_W-2:0], 1'b0};
                        r_bit_cnt <= '0;
                    end
                    ST_DATA: begin
                        r_ack     <= r_shift[DATA_W-1];
                        r_shift   <= {r_shift[DATA_W-2:0], 1'b0};
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    end
                    default: begin
                        r_state <= ST_PRE1;
                        r_ack   <= ACK_PREAMBLE;
                    end
                endcase
            end
        end
    end

    assign testack    = r_ack;
    assign word_sent  = r_word_sent;
    assign word_abort = r_word_abort;
    assign break_det  = r_break_det;

endmodule

// File: tb/tb_postbox_input_engine.sv
// Self-checking bench for postbox_input_engine. The host side is modelled as a
// stream of expected ACK bits derived from the INPUT protocol rules; a monitor
// pops and compares one expected bit on every REQ rise.
module tb_postbox_input_engine;

    localparam int DATA_W       = 8;
    localparam int FIFO_DEPTH   = 8;
    localparam int BREAK_CYCLES = 40;
    localparam int SYNC_STAGES  = 2;
    localparam int LVL_W        = $clog2(FIFO_DEPTH) + 1;
`ifdef POSTBOX_TXFIFO_EN
    localparam int EFF_DEPTH = FIFO_DEPTH;
`else
    localparam int EFF_DEPTH = 1;
`endif

    // Slot tokens of the host-side model.
    localparam int TK_ACK   = 1;
    localparam int TK_LAST  = 2;
    localparam int TK_DATA  = 4;
    localparam int TK_XSLOT = 8;

    logic              refclk    = 1'b0;
    logic              rst_n     = 1'b0;
    logic              testreq   = 1'b0;
    logic              out_ready = 1'b0;
    logic              tx_wr     = 1'b0;
    logic [DATA_W-1:0] tx_data   = '0;
    wire               testack;
    wire               tx_full;
    wire  [LVL_W-1:0]  tx_level;
    wire               word_sent;
    wire               word_abort;
    wire               break_det;

    postbox_input_engine #(
        .DATA_W       (DATA_W),
        .FIFO_DEPTH   (FIFO_DEPTH),
        .BREAK_CYCLES (BREAK_CYCLES),
        .SYNC_STAGES  (SYNC_STAGES)
    ) dut (
        .refclk     (refclk),
        .rst_n      (rst_n),
        .testreq    (testreq),
        .testack    (testack),
        .out_ready  (out_ready),
        .tx_data    (tx_data),
        .tx_wr      (tx_wr),
        .tx_full    (tx_full),
        .tx_level   (tx_level),
        .word_sent  (word_sent),
        .word_abort (word_abort),
        .break_det  (break_det)
    );

    always #5 refclk = ~refclk;

    int m_fifo[$];
    int m_stream[$];
    int m_cur;
    bit m_armed;
    int exp_q[$];
    int exp_sent, exp_brk, exp_abort;
    int n_sent, n_brk, n_abort;
    int n_checks, n_errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // After a break or reset: two preamble zeros, then x (sampled on arrival), then y.
    function automatic void model_restart();
        m_cur = 0;
        m_stream.delete();
        m_stream.push_back(0);
        m_stream.push_back(TK_XSLOT);
    endfunction

    // One host pulse: record the bit it must see, then work out the following slot.
    function automatic void model_pulse();
        int w;
        exp_q.push_back(m_cur & TK_ACK);
        if ((m_cur & TK_LAST) != 0) exp_sent++;
        m_armed = 1'b1;
        if (m_stream.size() > 0) begin
            m_cur = m_stream.pop_front();
            if (m_cur == TK_XSLOT) m_cur = int'(out_ready);
        end else if (m_fifo.size() > 0) begin
            w = m_fifo.pop_front();
            for (int i = DATA_W - 1; i >= 0; i--) begin
                m_stream.push_back(TK_DATA | ((w >> i) & 1) | ((i == 0) ? TK_LAST : 0));
            end
            m_cur = 1;
        end else begin
            m_cur = 0;
        end
    endfunction

    // ACK scoreboard: the host samples testack as REQ rises.
    always @(posedge testreq) begin
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL ack_unexpected actual %0b expected none at %0t", testack, $time);
        end else begin
            check("ack", testack, exp_q.pop_front());
        end
    end

    // Pulse output monitor, sampled on the falling edge.
    always @(negedge refclk) begin
        if (rst_n) begin
            if (break_det) n_brk++;
            if (word_sent) n_sent++;
            if (word_abort) begin
                n_abort++;
                check("abort_with_break", break_det, 1);
            end
        end
    end

    task automatic pulse();
        int pw;
        int pg;
        pw = $urandom_range(2, 4);
        pg = $urandom_range(3, 5);
        @(posedge refclk);
        #1;
        model_pulse();
        testreq = 1'b1;
        repeat (pw) @(posedge refclk);
        #1;
        testreq = 1'b0;
        repeat (pg) @(posedge refclk);
        #1;
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) pulse();
    endtask

    task automatic do_break();
        @(posedge refclk);
        #1;
        testreq = 1'b0;
        if (m_armed) begin
            exp_brk++;
            if ((m_cur & TK_DATA) != 0) exp_abort++;
        end
        m_armed = 1'b0;
        model_restart();
        repeat (BREAK_CYCLES + 6) @(posedge refclk);
        #1;
        check("ack_after_break", testack, 0);
    endtask

    task automatic write_word(input logic [DATA_W-1:0] w);
        @(posedge refclk);
        #1;
        tx_data = w;
        tx_wr   = 1'b1;
        if (m_fifo.size() < EFF_DEPTH) m_fifo.push_back(int'(w));
        @(posedge refclk);
        #1;
        tx_wr = 1'b0;
        check("tx_level", tx_level, m_fifo.size());
        check("tx_full", tx_full, (m_fifo.size() == EFF_DEPTH) ? 1 : 0);
    endtask

    task automatic check_counts();
        check("break_det_count", n_brk, exp_brk);
        check("word_sent_count", n_sent, exp_sent);
        check("word_abort_count", n_abort, exp_abort);
        check("ack_queue_drained", exp_q.size(), 0);
        check("tx_level_idle", tx_level, m_fifo.size());
    endtask

    task automatic apply_reset(input int idle);
        @(posedge refclk);
        #1;
        rst_n   = 1'b0;
        testreq = 1'b0;
        tx_wr   = 1'b0;
        m_fifo.delete();
        model_restart();
        repeat (3) @(posedge refclk);
        #1;
        check("rst_testack", testack, 0);
        check("rst_tx_full", tx_full, 0);
        check("rst_tx_level", tx_level, 0);
        check("rst_word_sent", word_sent, 0);
        check("rst_word_abort", word_abort, 0);
        check("rst_break_det", break_det, 0);
        rst_n = 1'b1;
        // REQ is low out of reset, so the counter reaches one break on its own.
        exp_brk++;
        m_armed = 1'b0;
        repeat (idle) @(posedge refclk);
        #1;
        check("idle_testack", testack, 0);
        check_counts();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int op;
        // Reset and a long idle: exactly one break.
        apply_reset(2 * BREAK_CYCLES);

        // Empty FIFO, out_ready=1: 0,0,1,0 then y stays 0.
        out_ready = 1'b1;
        do_break();
        pulses(4);
        pulses(3);
        check_counts();

        // Single word 0x5A.
        write_word(8'h5A);
        do_break();
        pulses(4);
        check("level_after_pop", tx_level, 0);
        pulses(DATA_W);
        check_counts();

        // Chained words.
        k = (EFF_DEPTH < 5) ? EFF_DEPTH : 5;
        for (int i = 0; i < k; i++) write_word(8'h5A);
        out_ready = 1'b0;
        do_break();
        pulses(4 + k * (DATA_W + 1));
        check_counts();

        // Fill, overfill (dropped), then drain in order.
        for (int i = 0; i < EFF_DEPTH; i++) write_word(DATA_W'($urandom));
        write_word(8'hEE);
        check("full_after_overfill", tx_full, 1);
        do_break();
        pulses(4 + EFF_DEPTH * (DATA_W + 1));
        check_counts();

        // Break during data bits.
        write_word(8'hA5);
        do_break();
        pulses(4 + 3);
        do_break();
        check("level_after_abort", tx_level, 0);
        pulses(4);
        check_counts();

        // Reset in the middle of a transfer drops everything.
        for (int i = 0; i < EFF_DEPTH; i++) write_word(DATA_W'($urandom));
        do_break();
        pulses(4 + 2);
        apply_reset(BREAK_CYCLES + 6);
        do_break();
        pulses(4);
        check_counts();

        // Random mix of writes, breaks, out_ready changes and pulses.
        for (int i = 0; i < 200; i++) begin
            op = $urandom_range(0, 9);
            if (op <= 2) begin
                write_word(DATA_W'($urandom));
            end else if (op == 3) begin
                do_break();
            end else if (op == 4) begin
                out_ready = 1'($urandom);
            end else begin
                pulse();
            end
        end
        do_break();
        check_counts();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
